// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage (I) and
// the memory stage (D). It serves one access at a time. When both stages
// request in the same cycle, the grant alternates between them. A fetch that
// is flushed mid-flight still completes on the bus, but it is never reported
// back to the fetch stage.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // fetch port
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic                  i_flush_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_done_o,
  output logic                  i_stall_o,
  // data port
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_done_o,
  output logic                  d_stall_o,
  // memory port
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  // access latched at grant time; it drives the memory port while busy
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } mreq_t;

  state_t                state_q, state_d;
  mreq_t                 req_q, req_d;
  // last_d also names the owner of the access in flight, since it is
  // written on every grant
  logic                  last_d_q, last_d_d;
  logic                  cancel_q, cancel_d;
  logic                  i_cap, d_cap;
  logic                  fetch_ok;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  assign fetch_ok = i_req_i & ~i_flush_i;

  // next-state logic: grant selection, bus wait, completion
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    last_d_d = last_d_q;
    cancel_d = cancel_q;
    i_cap    = 1'b0;
    d_cap    = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        // D wins unless an eligible fetch was passed over last time
        if (d_req_i && (!fetch_ok || !last_d_q)) begin
          state_d     = BUSY_D;
          req_d.addr  = d_addr_i;
          req_d.we    = d_we_i;
          req_d.wdata = d_wdata_i;
          last_d_d    = 1'b1;
        end else if (fetch_ok) begin
          state_d    = BUSY_I;
          req_d.addr = i_addr_i;
          req_d.we   = 1'b0;
          last_d_d   = 1'b0;
        end
      end
      BUSY_I: begin
        if (i_flush_i) cancel_d = 1'b1;
        if (mem_ready_i) begin
          // a flush in the completing cycle also discards the word
          i_cap   = ~cancel_q & ~i_flush_i;
          state_d = RESP;
        end
      end
      BUSY_D: begin
        if (mem_ready_i) begin
          d_cap   = ~req_q.we;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, latched access and read-data registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      last_d_q  <= 1'b0;
      cancel_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      last_d_q <= last_d_d;
      cancel_q <= cancel_d;
      if (i_cap) i_rdata_q <= mem_rdata_i;
      if (d_cap) d_rdata_q <= mem_rdata_i;
    end
  end

  assign mem_req_o   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_we_o    = (state_q == BUSY_D) & req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;

  assign i_done_o  = (state_q == RESP) & ~last_d_q & ~cancel_q;
  assign d_done_o  = (state_q == RESP) &  last_d_q;
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;

  // fetch freezes behind any data stall
  assign d_stall_o = d_req_i & ~d_done_o;
  assign i_stall_o = (i_req_i | d_stall_o) & ~i_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          i_req_i, i_flush_i, i_done_o, i_stall_o;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i, d_we_i, d_done_o, d_stall_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
    .i_rdata_o(i_rdata_o), .i_done_o(i_done_o), .i_stall_o(i_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic cmp1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one transaction record) ----------------
  // m_owner: 0 none, 1 fetch, 2 data; m_resp: access finished, reporting now
  int          m_owner  = 0;
  bit          m_resp   = 0;
  bit          m_cancel = 0;
  bit          m_last_d = 0;
  bit          m_we     = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  // advance the transaction using the inputs present at the edge
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_owner <= 0; m_resp <= 0; m_cancel <= 0; m_last_d <= 0;
      m_i_rdata <= '0; m_d_rdata <= '0;
    end else if (m_resp) begin
      m_owner <= 0; m_resp <= 0; m_cancel <= 0;
    end else if (m_owner == 1) begin
      if (i_flush_i) m_cancel <= 1;
      if (mem_ready_i) begin
        m_resp <= 1;
        if (!m_cancel && !i_flush_i) m_i_rdata <= mem_rdata_i;
      end
    end else if (m_owner == 2) begin
      if (mem_ready_i) begin
        m_resp <= 1;
        if (!m_we) m_d_rdata <= mem_rdata_i;
      end
    end else if (d_req_i && !(i_req_i && !i_flush_i && m_last_d)) begin
      m_owner <= 2; m_addr <= d_addr_i; m_we <= d_we_i; m_wdata <= d_wdata_i; m_last_d <= 1;
    end else if (i_req_i && !i_flush_i) begin
      m_owner <= 1; m_addr <= i_addr_i; m_we <= 0; m_last_d <= 0;
    end
  end

  task automatic check_cycle();
    logic busy, ei, ed, est_d;
    if (rst_i) begin
      ei = 1'b0; ed = 1'b0;
      cmp1("rst_mem_req", mem_req_o, 1'b0);
      cmp1("rst_mem_we", mem_we_o, 1'b0);
      cmp32("rst_mem_addr", mem_addr_o, 32'h0);
      cmp32("rst_mem_wdata", mem_wdata_o, 32'h0);
      cmp1("rst_i_done", i_done_o, 1'b0);
      cmp1("rst_d_done", d_done_o, 1'b0);
      cmp32("rst_i_rdata", i_rdata_o, 32'h0);
      cmp32("rst_d_rdata", d_rdata_o, 32'h0);
    end else begin
      busy = (m_owner != 0) && !m_resp;
      ei   = m_resp && (m_owner == 1) && !m_cancel;
      ed   = m_resp && (m_owner == 2);
      cmp1("mem_req", mem_req_o, busy);
      cmp1("i_done", i_done_o, ei);
      cmp1("d_done", d_done_o, ed);
      cmp32("i_rdata", i_rdata_o, m_i_rdata);
      cmp32("d_rdata", d_rdata_o, m_d_rdata);
      if (busy) begin
        cmp32("mem_addr", mem_addr_o, m_addr);
        cmp1("mem_we", mem_we_o, (m_owner == 2) && m_we);
        if ((m_owner == 2) && m_we) cmp32("mem_wdata", mem_wdata_o, m_wdata);
      end
    end
    est_d = d_req_i && !ed;
    cmp1("d_stall", d_stall_o, est_d);
    cmp1("i_stall", i_stall_o, (i_req_i || est_d) && !ei);
  endtask

  // done flags seen just before the next edge, for the random requesters
  logic s_i_done = 1'b0;
  logic s_d_done = 1'b0;

  // compare every cycle, away from the active edge
  always @(negedge clk_i) begin
    s_i_done <= i_done_o;
    s_d_done <= d_done_o;
    check_cycle();
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  task automatic zero_inputs();
    i_req_i = 0; i_addr_i = '0; i_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
  endtask

  // leaves the bench at edge+1 of the first cycle out of reset
  task automatic do_reset();
    rst_i = 1;
    zero_inputs();
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 0;
  endtask

  initial begin
    int  cnt_st, cnt_done;
    bit  i_kill;
    i_kill = 0;

    do_reset();
    @(negedge clk_i);
    cmp1("reset_mem_req", mem_req_o, 1'b0);
    cmp32("reset_i_rdata", i_rdata_o, 32'h0);
    cmp32("reset_d_rdata", d_rdata_o, 32'h0);
    nxt();

    // fetch 0x100, memory ready on the first bus cycle
    i_req_i = 1; i_addr_i = 32'h100; mem_ready_i = 1; mem_rdata_i = 32'h12345678;
    @(negedge clk_i);
    cmp1("f_c0_mem_req", mem_req_o, 1'b0);
    cmp1("f_c0_i_stall", i_stall_o, 1'b1);
    nxt();
    @(negedge clk_i);
    cmp1("f_c1_mem_req", mem_req_o, 1'b1);
    cmp32("f_c1_mem_addr", mem_addr_o, 32'h100);
    nxt();
    mem_rdata_i = 32'hBADBAD00;  // ready/rdata in RESP must be ignored
    @(negedge clk_i);
    cmp1("f_c2_i_done", i_done_o, 1'b1);
    cmp32("f_c2_i_rdata", i_rdata_o, 32'h12345678);
    cmp32("f_c2_model_i_rdata", m_i_rdata, 32'h12345678);
    cmp1("f_c2_i_stall", i_stall_o, 1'b0);
    nxt();
    i_req_i = 0;
    @(negedge clk_i);
    cmp1("f_c3_i_done", i_done_o, 1'b0);
    cmp32("f_c3_i_rdata", i_rdata_o, 32'h12345678);
    nxt();
    mem_ready_i = 0;
    nxt();

    // simultaneous requests alternate, D first out of reset
    do_reset();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200; i_req_i = 1; i_addr_i = 32'h300;
    mem_ready_i = 1; mem_rdata_i = 32'h0A0A0A0A;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      if (k == 1 || k == 7) cmp32("alt_grant_d", mem_addr_o, 32'h200);
      if (k == 4) cmp32("alt_grant_i", mem_addr_o, 32'h300);
      if (k == 2 || k == 8) cmp1("alt_d_done", d_done_o, 1'b1);
      if (k == 5) cmp1("alt_i_done", i_done_o, 1'b1);
      if (k == 4) cmp1("alt_model_last_d", m_last_d, 1'b0);
      nxt();
    end
    d_req_i = 0; i_req_i = 0; mem_ready_i = 0;
    nxt();

    // load with ready delayed to cycle 3
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h80;
    cnt_st = 0; cnt_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin mem_ready_i = 1; mem_rdata_i = 32'hCAFEF00D; end
      if (k == 5) begin d_req_i = 0; mem_ready_i = 0; end
      @(negedge clk_i);
      if (d_stall_o && i_stall_o) cnt_st++;
      if (d_done_o) cnt_done++;
      if (k == 4) begin
        cmp1("ld_resp_mem_req", mem_req_o, 1'b0);
        cmp32("ld_d_rdata", d_rdata_o, 32'hCAFEF00D);
      end
      nxt();
    end
    cmp32("ld_stall_cycles", cnt_st, 32'd4);
    cmp32("ld_done_pulses", cnt_done, 32'd1);

    // store 0xDEADBEEF to 0x40 leaves load data untouched
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h40; d_wdata_i = 32'hDEADBEEF;
    mem_ready_i = 1; mem_rdata_i = 32'h55555555;
    nxt();
    @(negedge clk_i);
    cmp1("st_mem_we", mem_we_o, 1'b1);
    cmp32("st_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    cmp32("st_mem_addr", mem_addr_o, 32'h40);
    nxt();
    @(negedge clk_i);
    cmp1("st_d_done", d_done_o, 1'b1);
    cmp32("st_d_rdata", d_rdata_o, 32'hCAFEF00D);
    nxt();
    d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
    nxt();

    // flush during a fetch: bus completes, fetch stage never hears of it
    do_reset();
    i_req_i = 1; i_addr_i = 32'h10; mem_ready_i = 1; mem_rdata_i = 32'h11111111;
    nxt(); nxt();
    @(negedge clk_i);
    cmp1("fl_first_done", i_done_o, 1'b1);
    nxt();
    i_req_i = 0; mem_ready_i = 0;
    nxt();
    i_req_i = 1; i_addr_i = 32'h20;
    nxt();
    i_flush_i = 1;
    @(negedge clk_i);
    cmp1("fl_busy_mem_req", mem_req_o, 1'b1);
    nxt();
    i_flush_i = 0; i_req_i = 0;
    nxt();
    mem_ready_i = 1; mem_rdata_i = 32'h22222222;
    nxt();
    i_req_i = 1; i_addr_i = 32'h30; mem_rdata_i = 32'h33333333;
    @(negedge clk_i);
    cmp1("fl_resp_no_done", i_done_o, 1'b0);
    cmp32("fl_resp_i_rdata", i_rdata_o, 32'h11111111);
    cmp1("fl_resp_mem_req", mem_req_o, 1'b0);
    nxt();
    @(negedge clk_i);
    cmp1("fl_idle_mem_req", mem_req_o, 1'b0);
    nxt();
    @(negedge clk_i);
    cmp1("fl_next_mem_req", mem_req_o, 1'b1);
    cmp32("fl_next_addr", mem_addr_o, 32'h30);
    nxt();
    @(negedge clk_i);
    cmp1("fl_next_done", i_done_o, 1'b1);
    cmp32("fl_next_rdata", i_rdata_o, 32'h33333333);
    nxt();
    i_req_i = 0; mem_ready_i = 0;
    nxt();

    // reset mid data access
    do_reset();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
    nxt();
    @(negedge clk_i);
    cmp1("rs_busy_mem_req", mem_req_o, 1'b1);
    #1 rst_i = 1;
    #1;
    cmp1("rs_mem_req_drop", mem_req_o, 1'b0);
    cmp1("rs_no_done", d_done_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 0; d_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      cmp1("rs_trail_mem_req", mem_req_o, 1'b0);
      cmp1("rs_trail_done", d_done_o, 1'b0);
      cmp32("rs_trail_d_rdata", d_rdata_o, 32'h0);
      nxt();
    end
    mem_ready_i = 0;

    // randomized requesters and memory
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (rst_i) begin
        rst_i = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_i = 1; i_req_i = 0; d_req_i = 0; i_flush_i = 0; i_kill = 0;
      end
      if (!rst_i) begin
        i_flush_i = 0;
        if (i_req_i && (s_i_done || i_kill)) i_req_i = 0;
        i_kill = 0;
        if (!i_req_i) begin
          if ($urandom_range(0, 3) == 0) begin
            i_req_i = 1; i_addr_i = $urandom() & 32'hFFFF_FFFC;
          end else if ($urandom_range(0, 29) == 0) begin
            i_flush_i = 1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          i_flush_i = 1; i_kill = 1;
        end
        if (d_req_i && s_d_done) d_req_i = 0;
        if (!d_req_i && $urandom_range(0, 2) == 0) begin
          d_req_i = 1; d_we_i = 1'($urandom_range(0, 1));
          d_addr_i = $urandom() & 32'hFFFF_FFFC; d_wdata_i = $urandom();
        end
      end
      mem_ready_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i = $urandom();
      nxt();
    end

    rst_i = 0;
    zero_inputs();
    nxt(); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, sets the width of all data ports.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 i_req_i  input  1  fetch-stage read request; held high until i_done_o or i_flush_i.
REQ-006 i_addr_i  input  ADDR_WIDTH  fetch address; stable while i_req_i is high.
REQ-007 i_flush_i  input  1  fetch request cancelled (branch/jump redirect).
REQ-008 i_rdata_o  output  DATA_WIDTH  fetched instruction word.
REQ-009 i_done_o  output  1  one-cycle pulse; i_rdata_o valid.
REQ-010 i_stall_o  output  1  stall request toward the fetch stage.
REQ-011 d_req_i  input  1  memory-stage request; held high until d_done_o.
REQ-012 d_we_i  input  1  1 = store, 0 = load.
REQ-013 d_addr_i  input  ADDR_WIDTH  data address.
REQ-014 d_wdata_i  input  DATA_WIDTH  store data.
REQ-015 d_rdata_o  output  DATA_WIDTH  load data.
REQ-016 d_done_o  output  1  one-cycle pulse; access complete, d_rdata_o valid for loads.
REQ-017 d_stall_o  output  1  stall request toward the memory stage and all earlier stages.
REQ-018 mem_req_o / mem_we_o  output  1 each  single-port memory request and write enable.
REQ-019 mem_addr_o / mem_wdata_o  output  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-020 mem_ready_i / mem_rdata_i  input  1 / DATA_WIDTH  memory completion strobe and read data.

Function
REQ-021 States SHALL be IDLE, BUSY_I, BUSY_D and RESP, with a 1-bit register last_d (previous grant was data).
REQ-022 In IDLE with only d_req_i high, the arbiter SHALL go to BUSY_D, latching d_addr_i, d_we_i and d_wdata_i, and SHALL set last_d=1.
REQ-023 In IDLE with only i_req_i high and i_flush_i low, the arbiter SHALL go to BUSY_I, latching i_addr_i, and SHALL set last_d=0.
REQ-024 In IDLE with both requests high, the grant SHALL go to I if last_d=1, otherwise to D.
REQ-025 In IDLE, a fetch request with i_flush_i high SHALL NOT be granted.
REQ-026 mem_req_o SHALL be 1 exactly while in BUSY_I or BUSY_D; mem_addr_o, mem_we_o and mem_wdata_o SHALL come from the latched registers (mem_we_o=0 in BUSY_I).
REQ-027 In BUSY_x, the arbiter SHALL remain in that state until mem_ready_i=1; that cycle it SHALL capture mem_rdata_i and go to RESP.
REQ-028 In RESP, the arbiter SHALL assert exactly one of d_done_o or i_done_o for the owner, SHALL then return to IDLE, and SHALL evaluate no new grant during RESP.
REQ-029 d_rdata_o and i_rdata_o SHALL be registered and change only on a load/fetch capture; a store SHALL leave d_rdata_o unchanged.
REQ-030 Minimum latency SHALL be request seen in cycle 0, mem_req_o in cycle 1, mem_ready_i in cycle 1, done in cycle 2.
REQ-031 i_flush_i high in BUSY_I SHALL set a cancel flag; the memory access SHALL still complete, RESP SHALL then suppress i_done_o and leave i_rdata_o unchanged, and the flag SHALL clear in IDLE.
REQ-032 i_flush_i in BUSY_D or RESP (data owner) SHALL have no effect.
REQ-033 d_stall_o SHALL equal d_req_i and not d_done_o (combinational).
REQ-034 i_stall_o SHALL equal (i_req_i or d_stall_o) and not i_done_o (combinational), so the fetch stage freezes behind a data stall.
REQ-035 mem_ready_i in IDLE or RESP SHALL be ignored.

Reset
REQ-036 While rst_i is high (asynchronous), the arbiter SHALL force IDLE, last_d=0, cancel flag 0, all done and mem_* outputs 0, and both rdata registers 0.
REQ-037 Reset asserted mid-access SHALL drop mem_req_o in the same cycle, SHALL produce no done pulse, and SHALL cause a later mem_ready_i to be ignored.

Verification
REQ-038 Fetch only, addr 0x100, mem_ready_i on first request cycle -> mem_req_o in cycle 1, i_done_o in cycle 2, i_rdata_o = mem_rdata_i.
REQ-039 Both requests in IDLE after reset -> D granted first; next conflict -> I granted; grants alternate thereafter.
REQ-040 Load, mem_ready_i delayed 3 cycles -> d_stall_o and i_stall_o high 4 cycles, d_done_o single pulse, no new mem_req_o in RESP.
REQ-041 i_flush_i during BUSY_I, ready 2 cycles later -> no i_done_o, i_rdata_o unchanged, next fetch granted from IDLE.
REQ-042 Store 0xDEADBEEF to 0x40 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, d_rdata_o unchanged.
REQ-043 rst_i pulsed in BUSY_D -> mem_req_o low immediately, no d_done_o, trailing mem_ready_i ignored.
